seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider for unsigned WIDTH-bit operands.
// Produces one quotient bit per clock after a start/busy/done handshake.
// Divide-by-zero takes a short path: Q = all ones, R = dividend, DZ = 1.
// Q, R and DZ are registered. They hold their value until the next result
// is written, so a consumer may read them at any time after done.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             DZ
);

  // The bit counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvs;   // captured divisor
  logic [WIDTH-1:0] r_dvd;   // dividend shift register; fills with quotient bits
  logic [WIDTH-1:0] r_rem;   // partial remainder
  logic [CW-1:0]    r_cnt;   // quotient bits still to produce
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [WIDTH:0]   w_shift;     // {rem, next dividend bit}
  logic [WIDTH:0]   w_trial;     // shifted remainder minus divisor
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_dvd_next;
  logic             w_last;

  // One restoring step. The trial is WIDTH+1 bits wide because the shifted
  // remainder can reach 2*divisor-1. That value does not fit in WIDTH bits
  // when the remainder is at least 2^(WIDTH-1).
  always_comb begin
    w_shift    = {r_rem, r_dvd[WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_dvs};
    w_rem_next = w_shift[WIDTH-1:0];
    w_qbit     = 1'b0;
    if (w_trial[WIDTH] == 1'b0) begin
      w_rem_next = w_trial[WIDTH-1:0];
      w_qbit     = 1'b1;
    end else begin
      w_rem_next = w_shift[WIDTH-1:0];
      w_qbit     = 1'b0;
    end
    w_dvd_next = {r_dvd[WIDTH-2:0], w_qbit};
    w_last     = (r_cnt == CNT_ONE);
  end

  // Control FSM and datapath registers; all outputs are driven from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dvs   <= W_ZERO;
      r_dvd   <= W_ZERO;
      r_rem   <= W_ZERO;
      r_cnt   <= CNT_ZERO;
      r_q     <= W_ZERO;
      r_r     <= W_ZERO;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless a result is written on this edge.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvs  <= B;
            r_dvd  <= A;
            r_busy <= 1'b1;
            if (B == W_ZERO) begin
              r_rem   <= W_ZERO;
              r_cnt   <= CNT_ZERO;
              r_state <= S_ZERO;
            end else begin
              r_rem   <= W_ZERO;
              r_cnt   <= CNT_LOAD;
              r_state <= S_RUN;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          r_rem <= w_rem_next;
          r_dvd <= w_dvd_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_q     <= w_dvd_next;
            r_r     <= w_rem_next;
            r_dz    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_ZERO: begin
          // The dividend register is not shifted in this path, so it still
          // holds the captured A.
          r_q     <= W_ONES;
          r_r     <= r_dvd;
          r_dz    <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign busy = r_busy;
  assign done = r_done;
  assign DZ   = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with WIDTH = 4.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       DZ;

  int n_asserts = 0;
  int n_fail    = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .DZ    (DZ)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for done, bounded. While waiting, busy must be high and Q must hold.
  task automatic wait_done(input logic [3:0] q0, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      chk("busy_while_run", {31'd0, busy}, 32'd1);
      chk("q_hold_while_busy", {28'd0, Q}, {28'd0, q0});
      tick();
      lat++;
    end
  endtask

  // One complete division from idle. The latency is counted from the accepting edge.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edz, input int elat, input string tag);
    int lat;
    logic [3:0] q0;
    q0 = Q;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(q0, lat);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_Q"}, {28'd0, Q}, {28'd0, eq});
    chk({tag, "_R"}, {28'd0, R}, {28'd0, er});
    chk({tag, "_DZ"}, {31'd0, DZ}, {31'd0, edz});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int lat2;
    int pulses;
    logic [3:0] q0;

    rst_n = 1'b0;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    tick();
    tick();
    chk("reset_Q", {28'd0, Q}, 32'd0);
    chk("reset_R", {28'd0, R}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_DZ", {31'd0, DZ}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors, worked out by hand.
    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, "d13_3");
    run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, "d15_1");
    run_div(4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 4, "d2_7");
    run_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4, "d15_15");
    run_div(4'd5, 4'd0, 4'd15, 4'd5, 1'b1, 1, "dz5_0");
    run_div(4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 4, "d6_2_clears_dz");

    // Exhaustive sweep, plus the identity A == Q*B + R with R < B.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          run_div(4'(a), 4'(b), 4'd15, 4'(a), 1'b1, 1, "sweep_dz");
        end else begin
          run_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 4, "sweep");
          chk("sweep_invariant", 32'(Q) * 32'(b) + 32'(R), 32'(a));
          chk("sweep_r_lt_b", {31'd0, (32'(R) < 32'(b))}, 32'd1);
        end
      end
    end

    // A start pulse while busy must be ignored.
    q0 = Q;
    A = 4'd9;
    B = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'd14;
    B = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    wait_done(q0, lat);
    chk("ignore_latency", lat + 2, 4);
    chk("ignore_Q", {28'd0, Q}, 32'd4);
    chk("ignore_R", {28'd0, R}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("ignore_no_second_done", pulses, 0);
    chk("ignore_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a division aborts it.
    A = 4'd12;
    B = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_Q", {28'd0, Q}, 32'd0);
    chk("midrst_R", {28'd0, R}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_DZ", {31'd0, DZ}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
    run_div(4'd7, 4'd3, 4'd2, 4'd1, 1'b0, 4, "after_rst_7_3");

    // With start held high, the second request is accepted in the done cycle.
    q0 = Q;
    A = 4'd11;
    B = 4'd4;
    start = 1'b1;
    tick();
    A = 4'd8;
    B = 4'd3;
    wait_done(q0, lat);
    chk("b2b_first_latency", lat, 4);
    chk("b2b_first_Q", {28'd0, Q}, 32'd2);
    chk("b2b_first_R", {28'd0, R}, 32'd3);
    q0 = Q;
    tick();
    start = 1'b0;
    wait_done(q0, lat2);
    chk("b2b_done_gap", lat2 + 1, 5);
    chk("b2b_second_Q", {28'd0, Q}, 32'd2);
    chk("b2b_second_R", {28'd0, R}, 32'd2);
    chk("b2b_second_DZ", {31'd0, DZ}, 32'd0);
    tick();
    chk("b2b_done_cleared", {31'd0, done}, 32'd0);
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
